// File: rtl/song_pkg.sv
// Shared song-memory constants and playback state encoding for the recorder and player.
package song_pkg;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned NOTE_W = 7;

   localparam logic [DATA_W-1:0] END_SIGNAL    = 8'h7C;
   localparam logic [DATA_W-1:0] BLANK_NOTE    = 8'h7F;
   localparam logic [ADDR_W-1:0] START_ADDRESS = 10'd753;
   localparam logic [ADDR_W-1:0] MAX_ADDRESS   = 10'd997;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      WAIT,
      HOLD
   } play_state_t;

endpackage

// File: rtl/note_timer.sv
// Note-period counter: counts 0..CYCLES-1 while enabled, flags the last count.
module note_timer #(
   parameter int unsigned CYCLES = 25000000
) (
   input  logic clk_100mhz,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic terminal_c
);

   localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

   logic [CNT_W-1:0] count;

   assign terminal_c = enable && (count == LAST);

   always_ff @(posedge clk_100mhz) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= terminal_c ? '0 : count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/song_player_sched.sv
// Song BRAM port owner: recorder writes take priority, a playback reader
// steps through the stored song and feeds notes to the tone generator.
module song_player_sched
   import song_pkg::*;
#(
   parameter int unsigned CYCLES_PER_NOTE = 25000000,
   parameter int unsigned BRAM_LATENCY    = 2
) (
   input  logic              clk_100mhz,
   input  logic              reset,
   input  logic              play_start,
   input  logic              play_stop,
   input  logic              rec_active,
   input  logic              rec_write_enable,
   input  logic [ADDR_W-1:0] rec_address,
   input  logic [DATA_W-1:0] rec_value,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_din,
   output logic              bram_we,
   input  logic [DATA_W-1:0] bram_dout,
   output logic [NOTE_W-1:0] note_out,
   output logic              note_valid,
   output logic              playing,
   output logic              done
);

   localparam int unsigned LAT_W = (BRAM_LATENCY > 1) ? $clog2(BRAM_LATENCY) : 1;

   play_state_t       state;
   logic [ADDR_W-1:0] play_addr;
   logic [LAT_W-1:0]  lat_cnt;
   logic              hold_done_c;
   logic              read_blank_c;

   note_timer #(
      .CYCLES (CYCLES_PER_NOTE)
   ) u_note_timer (
      .clk_100mhz (clk_100mhz),
      .reset      (reset),
      .clear      (state != HOLD),
      .enable     (state == HOLD),
      .terminal_c (hold_done_c)
   );

   // Recorder owns the port whenever it asks; the player reads in the gaps.
   assign bram_we   = rec_write_enable && !reset;
   assign bram_din  = rec_value;
   assign bram_addr = rec_write_enable ? rec_address : play_addr;

   // Any byte with the top bit set is not a playable note.
   assign read_blank_c = (bram_dout == BLANK_NOTE) || bram_dout[DATA_W-1];

   always_ff @(posedge clk_100mhz) begin
      if (reset) begin
         state      <= IDLE;
         play_addr  <= START_ADDRESS;
         lat_cnt    <= '0;
         note_out   <= '0;
         note_valid <= 1'b0;
         playing    <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         if ((state != IDLE) && (play_stop || rec_active)) begin
            state      <= IDLE;
            note_valid <= 1'b0;
            playing    <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (play_start && !rec_active && !play_stop) begin
                     state     <= FETCH;
                     play_addr <= START_ADDRESS;
                     playing   <= 1'b1;
                  end
               end
               FETCH: begin
                  if (!rec_write_enable) begin
                     state   <= WAIT;
                     lat_cnt <= LAT_W'(BRAM_LATENCY - 1);
                  end
               end
               WAIT: begin
                  if (lat_cnt != '0) begin
                     lat_cnt <= lat_cnt - LAT_W'(1);
                  end else if (bram_dout == END_SIGNAL) begin
                     state      <= IDLE;
                     done       <= 1'b1;
                     note_valid <= 1'b0;
                     playing    <= 1'b0;
                  end else if (read_blank_c) begin
                     note_valid <= 1'b0;
                     state      <= HOLD;
                  end else begin
                     note_out   <= bram_dout[NOTE_W-1:0];
                     note_valid <= 1'b1;
                     state      <= HOLD;
                  end
               end
               HOLD: begin
                  if (hold_done_c) begin
                     if (play_addr == MAX_ADDRESS) begin
                        state      <= IDLE;
                        done       <= 1'b1;
                        note_valid <= 1'b0;
                        playing    <= 1'b0;
                     end else begin
                        play_addr <= play_addr + ADDR_W'(1);
                        state     <= FETCH;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_song_player_sched.sv
// Directed bench for song_player_sched with a two-stage behavioural BRAM model.
module tb_song_player_sched;
   import song_pkg::*;

   localparam int unsigned CPN = 8;
   localparam int unsigned LAT = 2;

   logic              clk_100mhz = 1'b0;
   logic              reset;
   logic              play_start;
   logic              play_stop;
   logic              rec_active;
   logic              rec_write_enable;
   logic [ADDR_W-1:0] rec_address;
   logic [DATA_W-1:0] rec_value;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_din;
   logic              bram_we;
   logic [DATA_W-1:0] bram_dout;
   logic [NOTE_W-1:0] note_out;
   logic              note_valid;
   logic              playing;
   logic              done;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int done_cnt = 0;
   int over_cnt = 0;

   logic [DATA_W-1:0] mem [0:1023];
   logic [ADDR_W-1:0] addr_q;

   song_player_sched #(
      .CYCLES_PER_NOTE (CPN),
      .BRAM_LATENCY    (LAT)
   ) dut (
      .clk_100mhz       (clk_100mhz),
      .reset            (reset),
      .play_start       (play_start),
      .play_stop        (play_stop),
      .rec_active       (rec_active),
      .rec_write_enable (rec_write_enable),
      .rec_address      (rec_address),
      .rec_value        (rec_value),
      .bram_addr        (bram_addr),
      .bram_din         (bram_din),
      .bram_we          (bram_we),
      .bram_dout        (bram_dout),
      .note_out         (note_out),
      .note_valid       (note_valid),
      .playing          (playing),
      .done             (done)
   );

   always #5 clk_100mhz = ~clk_100mhz;

   // Address registered at issue, data registered one cycle later.
   always @(posedge clk_100mhz) begin
      if (bram_we) mem[bram_addr] <= bram_din;
      addr_q    <= bram_addr;
      bram_dout <= mem[addr_q];
   end

   always @(negedge clk_100mhz) begin
      if (done === 1'b1) done_cnt++;
      if (!rec_write_enable && (bram_addr > MAX_ADDRESS)) over_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_100mhz);
      cyc++;
   endtask

   task automatic goto(input int n);
      while (cyc < n) tick();
   endtask

   task automatic rec_write(input int a, input logic [7:0] v);
      rec_write_enable = 1'b1;
      rec_address      = 10'(a);
      rec_value        = v;
      tick();
      rec_write_enable = 1'b0;
   endtask

   task automatic start_play();
      cyc        = 0;
      play_start = 1'b1;
      tick();
      play_start = 1'b0;
   endtask

   function automatic logic [7:0] max_val(input int a);
      logic [9:0] av;
      logic [7:0] v;
      av = 10'(a);
      v  = {1'b0, av[6:0]};
      if (a == 760) v = 8'h85;
      else if (v == 8'h7C || v == 8'h7F) v = 8'h01;
      return v;
   endfunction

   // Note n of a song becomes valid at cycle 4 + 11*n after the start pulse.
   task automatic basic_run();
      int d0;
      rec_write(753, 8'h3C);
      rec_write(754, 8'h40);
      rec_write(755, 8'h7F);
      rec_write(756, 8'h7C);
      d0 = done_cnt;
      start_play();
      check("basic_playing", 32'(playing), 32'd1);
      check("basic_fetch_addr", 32'(bram_addr), 32'd753);
      goto(3);
      check("basic_wait_invalid", 32'(note_valid), 32'd0);
      goto(4);
      check("basic_note0", 32'(note_out), 32'h3C);
      check("basic_note0_valid", 32'(note_valid), 32'd1);
      goto(12);
      check("basic_fetch2_addr", 32'(bram_addr), 32'd754);
      goto(14);
      check("basic_note0_held", 32'(note_out), 32'h3C);
      goto(15);
      check("basic_note1", 32'(note_out), 32'h40);
      check("basic_note1_valid", 32'(note_valid), 32'd1);
      goto(26);
      check("basic_blank_valid", 32'(note_valid), 32'd0);
      check("basic_blank_note", 32'(note_out), 32'h40);
      goto(36);
      check("basic_pre_end_done", 32'(done), 32'd0);
      check("basic_pre_end_playing", 32'(playing), 32'd1);
      goto(37);
      check("basic_end_done", 32'(done), 32'd1);
      check("basic_end_playing", 32'(playing), 32'd0);
      goto(38);
      check("basic_done_pulse", 32'(done), 32'd0);
      check("basic_done_count", 32'(done_cnt - d0), 32'd1);
   endtask

   initial begin
      int d0;
      reset            = 1'b1;
      play_start       = 1'b0;
      play_stop        = 1'b0;
      rec_active       = 1'b0;
      rec_write_enable = 1'b1;
      rec_address      = 10'd5;
      rec_value        = 8'h00;
      tick();
      tick();
      check("rst_bram_we", 32'(bram_we), 32'd0);
      check("rst_playing", 32'(playing), 32'd0);
      check("rst_note_valid", 32'(note_valid), 32'd0);
      check("rst_note_out", 32'(note_out), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      reset            = 1'b0;
      rec_write_enable = 1'b0;
      #1;
      check("rst_play_addr", 32'(bram_addr), 32'd753);

      basic_run();

      // Recorder holds the port for five cycles while the player is in FETCH.
      rec_write(753, 8'h55);
      start_play();
      rec_write_enable = 1'b1;
      rec_address      = 10'd800;
      rec_value        = 8'hA5;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("prio_addr", 32'(bram_addr), 32'd800);
         check("prio_we", 32'(bram_we), 32'd1);
         tick();
      end
      check("prio_playing", 32'(playing), 32'd1);
      rec_write_enable = 1'b0;
      #1;
      check("prio_issue_addr", 32'(bram_addr), 32'd753);
      check("prio_issue_we", 32'(bram_we), 32'd0);
      goto(8);
      check("prio_wait_invalid", 32'(note_valid), 32'd0);
      goto(9);
      check("prio_note", 32'(note_out), 32'h55);
      check("prio_note_valid", 32'(note_valid), 32'd1);
      check("prio_written", 32'(mem[800]), 32'hA5);
      play_stop = 1'b1;
      tick();
      play_stop = 1'b0;
      check("prio_stop_playing", 32'(playing), 32'd0);

      // Aborts: user stop, record interlock, stop colliding with END.
      rec_write(753, 8'h11);
      rec_write(754, 8'h22);
      rec_write(755, 8'h7C);
      d0 = done_cnt;
      start_play();
      goto(15);
      check("abort_note1", 32'(note_out), 32'h22);
      goto(17);
      play_stop = 1'b1;
      tick();
      play_stop = 1'b0;
      check("abort_playing", 32'(playing), 32'd0);
      check("abort_valid", 32'(note_valid), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      start_play();
      check("restart_addr", 32'(bram_addr), 32'd753);
      goto(4);
      check("restart_note0", 32'(note_out), 32'h11);
      goto(5);
      rec_active = 1'b1;
      tick();
      check("recint_abort_playing", 32'(playing), 32'd0);
      check("recint_abort_valid", 32'(note_valid), 32'd0);
      play_start = 1'b1;
      tick();
      play_start = 1'b0;
      check("recint_start_ignored", 32'(playing), 32'd0);
      tick();
      check("recint_still_idle", 32'(playing), 32'd0);
      rec_active = 1'b0;
      start_play();
      goto(25);
      play_stop = 1'b1;
      tick();
      play_stop = 1'b0;
      check("stop_vs_end_done", 32'(done), 32'd0);
      check("stop_vs_end_playing", 32'(playing), 32'd0);
      check("stop_vs_end_valid", 32'(note_valid), 32'd0);
      tick();
      check("stop_vs_end_done_late", 32'(done), 32'd0);
      check("abort_done_count", 32'(done_cnt - d0), 32'd0);

      // Reset while the read is in flight.
      start_play();
      goto(2);
      reset            = 1'b1;
      rec_write_enable = 1'b1;
      rec_address      = 10'd900;
      rec_value        = 8'hEE;
      #1;
      check("midrst_we_low", 32'(bram_we), 32'd0);
      tick();
      check("midrst_playing", 32'(playing), 32'd0);
      check("midrst_valid", 32'(note_valid), 32'd0);
      check("midrst_note_out", 32'(note_out), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_no_write", 32'(mem[900] === 8'hEE), 32'd0);
      reset            = 1'b0;
      rec_write_enable = 1'b0;
      basic_run();

      // Song fills the whole region: playback must stop after address 997.
      for (int a = 753; a <= 997; a++) rec_write(a, max_val(a));
      d0 = done_cnt;
      start_play();
      goto(4);
      check("max_first_note", 32'(note_out), 32'(max_val(753) & 8'h7F));
      goto(81);
      check("max_hibit_blank", 32'(note_valid), 32'd0);
      check("max_hibit_note", 32'(note_out), 32'(max_val(759) & 8'h7F));
      goto(1104);
      check("max_mid_note", 32'(note_out), 32'(max_val(853) & 8'h7F));
      goto(2688);
      check("max_last_note", 32'(note_out), 32'(max_val(997) & 8'h7F));
      check("max_last_valid", 32'(note_valid), 32'd1);
      check("max_last_addr", 32'(bram_addr), 32'd997);
      goto(2695);
      check("max_pre_done", 32'(done), 32'd0);
      check("max_pre_playing", 32'(playing), 32'd1);
      goto(2696);
      check("max_done", 32'(done), 32'd1);
      check("max_playing", 32'(playing), 32'd0);
      check("max_valid", 32'(note_valid), 32'd0);
      goto(2697);
      check("max_done_pulse", 32'(done), 32'd0);
      check("max_done_count", 32'(done_cnt - d0), 32'd1);
      check("max_no_overrun", 32'(over_cnt), 32'd0);
      check("max_addr_parked", 32'(bram_addr), 32'd997);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/song_player_sched.md
Name: song_player_sched

Overview:
- Owns the single-port song BRAM port and shares it between two requesters: the recorder's write stream and a playback reader.
- Recorder writes always win. The playback reader fetches the recorded song from START_ADDRESS and holds each note for one note period.
- Playback stops on END_SIGNAL, at MAX_ADDRESS, on user stop, or when recording becomes active.
- Drives note_out/note_valid to the tone generator.

Parameters:
- END_SIGNAL, 8'h7C, end-of-song marker byte.
- BLANK_NOTE, 8'h7F, recorded silence.
- CYCLES_PER_NOTE, 25000000, hold time per note (0.25 s at 100 MHz).
- START_ADDRESS, 753, first song byte.
- MAX_ADDRESS, 997, last address playback may read.
- BRAM_LATENCY, 2, cycles from address issue to valid bram_dout.

Ports:
- clk_100mhz, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- play_start, input, 1, one-cycle pulse: begin playback.
- play_stop, input, 1, one-cycle pulse: abort playback.
- rec_active, input, 1, recorder enabled.
- rec_write_enable, input, 1, recorder write request.
- rec_address, input, 10, recorder write address.
- rec_value, input, 8, recorder write data.
- bram_addr, output, 10, BRAM address.
- bram_din, output, 8, BRAM write data.
- bram_we, output, 1, BRAM write enable.
- bram_dout, input, 8, BRAM read data.
- note_out, output, 7, current playback note.
- note_valid, output, 1, note_out should sound.
- playing, output, 1, high while the FSM is not IDLE.
- done, output, 1, one-cycle pulse on natural song end.

Behaviour:
- Reset:
  - FSM to IDLE; play_addr = START_ADDRESS.
  - note_out = 0, note_valid = 0, playing = 0, done = 0.
  - bram_we forced 0 while reset is high.
- Port mux (combinational):
  - bram_we = rec_write_enable.
  - bram_din = rec_value.
  - bram_addr = rec_write_enable ? rec_address : play_addr.
- FSM states: IDLE, FETCH, WAIT, HOLD.
- IDLE:
  - play_start && !rec_active && !play_stop → FETCH, play_addr = START_ADDRESS.
  - play_start while rec_active is ignored.
- FETCH:
  - If rec_write_enable, stall in FETCH (recorder priority).
  - Otherwise the read issues this cycle → WAIT, lat_cnt = BRAM_LATENCY-1.
- WAIT:
  - Decrement lat_cnt. At 0, sample bram_dout. The BRAM registered the address at issue, so later recorder writes do not corrupt the sample.
  - bram_dout == END_SIGNAL → IDLE, done pulses 1 cycle, note_valid = 0.
  - bram_dout == BLANK_NOTE → note_valid = 0, note_out unchanged, → HOLD.
  - bram_dout[7] == 1 (any other value) → treated as blank.
  - Otherwise → note_out = bram_dout[6:0], note_valid = 1, → HOLD.
- HOLD:
  - note timer counts 0..CYCLES_PER_NOTE-1.
  - On terminal count: if play_addr == MAX_ADDRESS → IDLE, done pulses, note_valid = 0. Else play_addr+1 → FETCH.
  - The previous note keeps sounding through the next FETCH/WAIT. Unstalled cadence = CYCLES_PER_NOTE + 1 + BRAM_LATENCY cycles per note.
- Aborts (any non-IDLE state):
  - play_stop or rec_active → IDLE next cycle, note_valid = 0, done stays 0.
  - play_stop has priority over a same-cycle play_start and over a same-cycle END detection.
- play_start while not IDLE is ignored; no restart.
- Reset mid-playback → IDLE immediately; timer and lat_cnt cleared.

Decomposition:
- song_pkg holds:
  - END_SIGNAL, BLANK_NOTE, START_ADDRESS, MAX_ADDRESS constants, shared with the recorder.
  - play_state_t enum {IDLE, FETCH, WAIT, HOLD}.
- One sub-module, note_timer: clear/enable inputs, terminal-count output, width $clog2(CYCLES_PER_NOTE).

Test Plan (CYCLES_PER_NOTE = 8, BRAM_LATENCY = 2, behavioural BRAM model):
- Basic playback:
  - Stimulus: BRAM[753..756] = 0x3C, 0x40, 0x7F, 0x7C; pulse play_start.
  - Required: note_out 0x3C (valid) for 8 cycles, then 0x40 (valid), then note_valid = 0 for 8 cycles; done pulses exactly once after reading 756; playing falls the same cycle.
- Recorder priority:
  - Stimulus: hold rec_write_enable high with rec_address = 800 for 5 cycles while the player is in FETCH.
  - Required: bram_addr = 800, bram_we = 1 for those cycles; the player stays in FETCH and issues play_addr the cycle after rec_write_enable drops; read data is correct.
- MAX boundary:
  - Stimulus: no END_SIGNAL anywhere in 753..997.
  - Required: playback reads through address 997, holds its note, then done pulses; no read of address 998 is ever issued.
- Abort:
  - Stimulus: play_stop during HOLD of the second note.
  - Required: next cycle IDLE, note_valid = 0, done = 0. A following play_start restarts at 753.
- Record interlock:
  - Stimulus: play_start while rec_active = 1.
  - Required: playing stays 0.
  - Stimulus: rec_active rising mid-playback.
  - Required: immediate abort.
- Reset mid-operation:
  - Stimulus: reset asserted during WAIT.
  - Required: all outputs at reset values next cycle, bram_we = 0 while reset is high; a new play_start behaves as in the basic playback scenario.
